// File: rtl/data_memory_sized.sv
// Byte-addressed MEM-stage data memory with byte/half/word sizing, lane-masked stores and a
// post-reset clear sequencer that zeroes the array and then plants two preset words.
module data_memory_sized #(
    parameter int          DEPTH    = 1024,
    parameter int          ADDR_W   = 32,
    parameter int          PRE_IDX0 = 32,
    parameter logic [31:0] PRE_VAL0 = 32'h0000_0005,
    parameter int          PRE_IDX1 = 33,
    parameter logic [31:0] PRE_VAL1 = 32'h0000_0006
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_uns,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              dbg_state_o
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       mem_q [DEPTH];

    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic              accept;
    logic [IDX_W-1:0]  word_idx;
    logic [1:0]        lane;
    logic              req_err;
    logic [31:0]       rd_word;
    logic [31:0]       rd_shift;
    logic [31:0]       ld_ext;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [3:0]        wr_mask;
    logic [31:0]       wr_data;

    // Handshake: a request is taken on any rising edge where req_valid && req_ready; req_ready is
    // low for the whole clear sequence so nothing is queued. Each taken request yields exactly one
    // rsp_valid pulse one cycle later; rsp_data/rsp_err hold between pulses.
    assign busy        = (state_q == ST_CLEAR);
    assign req_ready   = ~busy;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign dbg_state_o = state_q;

    assign accept   = req_valid && req_ready;
    assign word_idx = req_addr[IDX_W+1:2];
    assign lane     = req_addr[1:0];

    always_comb begin
        req_err = 1'b0;
        if ((req_addr >> (IDX_W + 2)) != '0)                   req_err = 1'b1;
        if (req_size == 2'b01 && req_addr[0])                  req_err = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)       req_err = 1'b1;
        if (req_size == 2'b11)                                 req_err = 1'b1;
    end

    // Combinational array read: a store committed on the previous edge is already visible here.
    assign rd_word  = mem_q[word_idx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        ld_ext = rd_word;
        case (req_size)
            2'b00:   ld_ext = req_uns ? {24'h0, rd_shift[7:0]}
                                      : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   ld_ext = req_uns ? {16'h0, rd_shift[15:0]}
                                      : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: ld_ext = rd_word;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = word_idx;
        wr_mask = 4'b0000;
        wr_data = 32'h0;
        if (state_q == ST_CLEAR && !rst) begin
            wr_en   = 1'b1;
            wr_idx  = cnt_q;
            wr_mask = 4'b1111;
            if (cnt_q == IDX_W'(PRE_IDX0))      wr_data = PRE_VAL0;
            else if (cnt_q == IDX_W'(PRE_IDX1)) wr_data = PRE_VAL1;
        end else if (accept && req_write && !req_err) begin
            wr_en = 1'b1;
            case (req_size)
                2'b00: begin
                    wr_mask = 4'b0001 << lane;
                    wr_data = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    wr_mask = 4'b0011 << lane;
                    wr_data = {2{req_wdata[15:0]}};
                end
                default: begin
                    wr_mask = 4'b1111;
                    wr_data = req_wdata;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
        end
    end

    always_comb begin
        rsp_valid_d = accept;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_err_d  = req_err;
            rsp_data_d = (req_write || req_err) ? 32'h0 : ld_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end
endmodule

// File: tb/tb_data_memory_sized.sv
// Bench for data_memory_sized: reset/clear timing, a table of sized loads/stores checked through an
// expected-response queue, clear restart, read-after-write and random word write/readback.
module tb_data_memory_sized;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        dbg_state;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [32:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[$];

    data_memory_sized dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_uns     (req_uns),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got err=%0b data=%08h, want err=%0b data=%08h",
                      name, act[32], act[31:0], exp[32], exp[31:0]);
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic e, input logic [31:0] d);
        vec_t v;
        v.wr = wr; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd; v.err = e; v.data = d;
        return v;
    endfunction

    // Response monitor: pops the oldest expectation on every rsp_valid pulse.
    always @(posedge clk) begin
        #1;
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_rsp", 33'd1, 33'd0);
            end else begin
                check(name_q.pop_front(), {rsp_err, rsp_data}, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input vec_t v, input string name);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = v.wr;
        req_size  = v.size;
        req_uns   = v.uns;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        exp_q.push_back({v.err, v.data});
        name_q.push_back(name);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic measure_clear(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy === 1'b1 && n < 2000);
        req_valid = 1'b0;
        check(name, {1'b0, 32'(n)}, {1'b0, 32'd1024});
    endtask

    initial begin
        logic [31:0] a, d;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10;
        req_uns = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  {32'h0, busy},      {32'h0, 1'b1});
        check("rst_ready", {32'h0, req_ready}, {32'h0, 1'b0});
        check("rst_rsp",   {rsp_err, rsp_data}, 33'h0);
        check("rst_valid", {32'h0, rsp_valid}, 33'h0);

        @(negedge clk);
        rst = 1'b0;
        measure_clear("clear_len");

        // Table: presets, sized stores/loads, extension, error cases
        tbl.push_back(mk(0, 2'b10, 0, 32'h080, 0, 0, 32'h0000_0005));
        tbl.push_back(mk(0, 2'b10, 0, 32'h084, 0, 0, 32'h0000_0006));
        tbl.push_back(mk(0, 2'b10, 0, 32'h000, 0, 0, 32'h0));
        tbl.push_back(mk(0, 2'b10, 0, 32'h088, 0, 0, 32'h0));
        tbl.push_back(mk(1, 2'b10, 0, 32'h100, 32'h8899AABB, 0, 32'h0));
        tbl.push_back(mk(1, 2'b00, 0, 32'h101, 32'hFFFFFF11, 0, 32'h0));
        tbl.push_back(mk(0, 2'b10, 0, 32'h100, 0, 0, 32'h889911BB));
        tbl.push_back(mk(0, 2'b00, 0, 32'h103, 0, 0, 32'hFFFFFF88));
        tbl.push_back(mk(0, 2'b00, 1, 32'h103, 0, 0, 32'h00000088));
        tbl.push_back(mk(0, 2'b00, 0, 32'h100, 0, 0, 32'hFFFFFFBB));
        tbl.push_back(mk(0, 2'b00, 0, 32'h101, 0, 0, 32'h00000011));
        tbl.push_back(mk(0, 2'b01, 0, 32'h100, 0, 0, 32'h000011BB));
        tbl.push_back(mk(0, 2'b01, 0, 32'h102, 0, 0, 32'hFFFF8899));
        tbl.push_back(mk(0, 2'b01, 1, 32'h102, 0, 0, 32'h00008899));
        tbl.push_back(mk(1, 2'b01, 0, 32'h202, 32'h12348001, 0, 32'h0));
        tbl.push_back(mk(0, 2'b01, 0, 32'h202, 0, 0, 32'hFFFF8001));
        tbl.push_back(mk(0, 2'b01, 1, 32'h202, 0, 0, 32'h00008001));
        tbl.push_back(mk(0, 2'b01, 0, 32'h200, 0, 0, 32'h0));
        tbl.push_back(mk(0, 2'b10, 0, 32'h200, 0, 0, 32'h80010000));
        tbl.push_back(mk(1, 2'b00, 0, 32'h200, 32'h123456AB, 0, 32'h0));
        tbl.push_back(mk(0, 2'b10, 0, 32'h200, 0, 0, 32'h800100AB));
        tbl.push_back(mk(1, 2'b10, 0, 32'hFFC, 32'hCAFEF00D, 0, 32'h0));
        tbl.push_back(mk(0, 2'b10, 0, 32'hFFC, 0, 0, 32'hCAFEF00D));
        tbl.push_back(mk(0, 2'b10, 0, 32'h102, 0, 1, 32'h0));
        tbl.push_back(mk(0, 2'b01, 0, 32'h201, 0, 1, 32'h0));
        tbl.push_back(mk(0, 2'b11, 0, 32'h100, 0, 1, 32'h0));
        tbl.push_back(mk(0, 2'b10, 0, 32'h1000, 0, 1, 32'h0));
        tbl.push_back(mk(0, 2'b00, 1, 32'h80000000, 0, 1, 32'h0));
        tbl.push_back(mk(1, 2'b10, 0, 32'h1000, 32'hFFFFFFFF, 1, 32'h0));
        tbl.push_back(mk(1, 2'b01, 0, 32'h101, 32'h0000FFFF, 1, 32'h0));
        tbl.push_back(mk(1, 2'b10, 0, 32'h202, 32'hFFFFFFFF, 1, 32'h0));
        tbl.push_back(mk(1, 2'b11, 0, 32'h100, 32'hFFFFFFFF, 1, 32'h0));
        tbl.push_back(mk(0, 2'b10, 0, 32'h000, 0, 0, 32'h0));
        tbl.push_back(mk(0, 2'b10, 0, 32'h100, 0, 0, 32'h889911BB));
        tbl.push_back(mk(0, 2'b10, 0, 32'h200, 0, 0, 32'h800100AB));
        for (int i = 0; i < tbl.size(); i++) issue(tbl[i], $sformatf("vec%0d", i));
        idle(3);
        check("drain_tbl", {1'b0, 32'(exp_q.size())}, 33'd0);

        // Hold: rsp_data/rsp_err keep the last response once rsp_valid drops
        issue(mk(0, 2'b10, 0, 32'h084, 0, 0, 32'h6), "hold_ld");
        idle(2);
        check("hold_valid", {32'h0, rsp_valid}, 33'h0);
        check("hold_data",  {rsp_err, rsp_data}, {1'b0, 32'h6});

        // Requests during clear are ignored; reset mid-clear restarts it
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h80;
        repeat (500) @(negedge clk);
        check("clear_ready", {32'h0, req_ready}, 33'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        measure_clear("clear_restart_len");
        check("busy_drop", {32'h0, busy}, 33'h0);

        issue(mk(0, 2'b10, 0, 32'h100, 0, 0, 32'h0), "recleared");
        issue(mk(0, 2'b10, 0, 32'h080, 0, 0, 32'h5), "represet0");
        issue(mk(0, 2'b10, 0, 32'h084, 0, 0, 32'h6), "represet1");
        issue(mk(1, 2'b10, 0, 32'h300, 32'h13579BDF, 0, 32'h0), "raw_st");
        issue(mk(0, 2'b10, 0, 32'h300, 0, 0, 32'h13579BDF), "raw_ld");
        for (int i = 0; i < 8; i++) begin
            a = 32'($urandom_range(256, 511)) << 2;
            d = $urandom();
            issue(mk(1, 2'b10, 0, a, d, 0, 32'h0), $sformatf("rnd_st%0d", i));
            issue(mk(0, 2'b10, 0, a, 0, 0, d), $sformatf("rnd_ld%0d", i));
            issue(mk(0, 2'b00, 1, a | 32'd2, 0, 0, {24'h0, d[23:16]}), $sformatf("rnd_lbu%0d", i));
        end
        idle(3);
        check("drain_end", {1'b0, 32'(exp_q.size())}, 33'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
